// File: rtl/bp_fe_pkg.sv
// Shared FE types for the predictor RAM port arbiter: FSM state and the
// queued attaboy entry (declared through a width-parameterised macro).
`define BP_FE_DECLARE_PRED_ARB_ENTRY_S(idx_width_mp, data_width_mp) \
    typedef struct packed {                                          \
        logic                     v;                                 \
        logic [idx_width_mp-1:0]  idx;                               \
        logic [data_width_mp-1:0] data;                              \
    } bp_fe_pred_arb_entry_s

package bp_fe_pkg;

    typedef enum logic {
        e_normal = 1'b0,
        e_force  = 1'b1
    } bp_fe_pred_arb_state_e;

    // Pointer width for a power-of-two circular buffer, never narrower than 1.
    function automatic int unsigned bp_fe_pred_arb_ptr_width(input int unsigned els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bp_fe_pred_arb_queue.sv
// Attaboy write queue: circular buffer with per-entry valid bits and a CAM
// invalidate port so redirect training is never overwritten by stale attaboys.
module bp_fe_pred_arb_queue
    import bp_fe_pkg::*;
#(
    parameter int idx_width_p  = 9,
    parameter int data_width_p = 2,
    parameter int els_p        = 4,
    localparam int ptr_width_lp = bp_fe_pred_arb_ptr_width(els_p),
    localparam int cnt_width_lp = ptr_width_lp + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enq_v_i,
    input  logic [idx_width_p-1:0]  enq_idx_i,
    input  logic [data_width_p-1:0] enq_data_i,
    input  logic                    deq_v_i,
    input  logic                    inv_v_i,
    input  logic [idx_width_p-1:0]  inv_idx_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    head_v_o,
    output logic [idx_width_p-1:0]  head_idx_o,
    output logic [data_width_p-1:0] head_data_o,
    output logic [cnt_width_lp-1:0] inv_hits_o
);

    `BP_FE_DECLARE_PRED_ARB_ENTRY_S(idx_width_p, data_width_p);

    // MSB of each pointer is the wrap bit.
    logic [ptr_width_lp:0]                  wptr_reg, rptr_reg;
    logic                                   enq, deq;
    logic [els_p-1:0]                       hit_vec;
    bp_fe_pred_arb_entry_s [els_p-1:0]      entries;
    bp_fe_pred_arb_entry_s                  head;

    assign empty_o = (wptr_reg == rptr_reg);
    assign full_o  = (wptr_reg[ptr_width_lp] != rptr_reg[ptr_width_lp])
                  && (wptr_reg[ptr_width_lp-1:0] == rptr_reg[ptr_width_lp-1:0]);
    assign enq     = enq_v_i & ~full_o;
    assign deq     = deq_v_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (enq) wptr_reg <= wptr_reg + (ptr_width_lp+1)'(1);
            if (deq) rptr_reg <= rptr_reg + (ptr_width_lp+1)'(1);
        end
    end

    // Valid bits double as occupancy: a popped slot is cleared, so the CAM
    // only ever matches live entries.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        bp_fe_pred_arb_entry_s entry_reg;

        assign hit_vec[gi] = inv_v_i & entry_reg.v & (entry_reg.idx == inv_idx_i);
        assign entries[gi] = entry_reg;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                entry_reg <= '0;
            end else if (enq && (wptr_reg[ptr_width_lp-1:0] == ptr_width_lp'(gi))) begin
                entry_reg <= '{v: 1'b1, idx: enq_idx_i, data: enq_data_i};
            end else if ((deq && (rptr_reg[ptr_width_lp-1:0] == ptr_width_lp'(gi))) || hit_vec[gi]) begin
                entry_reg.v <= 1'b0;
            end
        end
    end

    assign head        = entries[rptr_reg[ptr_width_lp-1:0]];
    assign head_v_o    = head.v;
    assign head_idx_o  = head.idx;
    assign head_data_o = head.data;

    always_comb begin
        inv_hits_o = '0;
        for (int i = 0; i < els_p; i++) begin
            inv_hits_o = inv_hits_o + cnt_width_lp'(hit_vec[i]);
        end
    end

endmodule

// File: rtl/bp_fe_pred_port_arbiter.sv
// Arbitrates a 1rw predictor RAM between redirect writes, fetch lookups and
// queued attaboy writes. Define BP_FE_PRED_ARB_PERF_EN for perf counters.
module bp_fe_pred_port_arbiter
    import bp_fe_pkg::*;
#(
    parameter int idx_width_p    = 9,
    parameter int data_width_p   = 2,
    parameter int fifo_els_p     = 4,
    parameter int starve_limit_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    redirect_v_i,
    input  logic [idx_width_p-1:0]  redirect_idx_i,
    input  logic [data_width_p-1:0] redirect_data_i,
    input  logic                    r_v_i,
    input  logic [idx_width_p-1:0]  r_idx_i,
    output logic                    r_yumi_o,
    input  logic                    attaboy_v_i,
    input  logic [idx_width_p-1:0]  attaboy_idx_i,
    input  logic [data_width_p-1:0] attaboy_data_i,
    output logic                    attaboy_yumi_o,
    output logic                    ram_v_o,
    output logic                    ram_w_o,
    output logic [idx_width_p-1:0]  ram_idx_o,
    output logic [data_width_p-1:0] ram_data_o,
    output logic                    forced_drain_o
`ifdef BP_FE_PRED_ARB_PERF_EN
    ,
    output logic [31:0]             perf_read_stall_o,
    output logic [31:0]             perf_attaboy_drop_o,
    output logic [31:0]             perf_force_o
`endif
);

    localparam int starve_width_lp = (starve_limit_p > 1) ? $clog2(starve_limit_p) : 1;
    localparam int hit_width_lp    = bp_fe_pred_arb_ptr_width(fifo_els_p) + 1;

    bp_fe_pred_arb_state_e        state_reg, state_next;
    logic [starve_width_lp-1:0]   starve_reg, starve_next;
    logic                         q_full, q_empty, head_v, deq;
    logic [idx_width_p-1:0]       head_idx;
    logic [data_width_p-1:0]      head_data;
    logic [hit_width_lp-1:0]      inv_hits;

    bp_fe_pred_arb_queue #(
        .idx_width_p (idx_width_p),
        .data_width_p(data_width_p),
        .els_p       (fifo_els_p)
    ) queue (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_v_i    (attaboy_yumi_o),
        .enq_idx_i  (attaboy_idx_i),
        .enq_data_i (attaboy_data_i),
        .deq_v_i    (deq),
        .inv_v_i    (redirect_v_i & ~reset_i),
        .inv_idx_i  (redirect_idx_i),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .head_v_o   (head_v),
        .head_idx_o (head_idx),
        .head_data_o(head_data),
        .inv_hits_o (inv_hits)
    );

    // No bypass: a drain in the same cycle does not make room for an attaboy.
    assign attaboy_yumi_o = attaboy_v_i & ~q_full & ~reset_i;
    assign forced_drain_o = (state_reg == e_force) & ~reset_i;

    always_comb begin
        ram_v_o    = 1'b0;
        ram_w_o    = 1'b0;
        ram_idx_o  = '0;
        ram_data_o = '0;
        r_yumi_o   = 1'b0;
        deq        = 1'b0;
        if (!reset_i) begin
            if (redirect_v_i) begin
                ram_v_o    = 1'b1;
                ram_w_o    = 1'b1;
                ram_idx_o  = redirect_idx_i;
                ram_data_o = redirect_data_i;
            // Forced drain outranks lookups; otherwise drain only when no lookup.
            end else if ((state_reg == e_force || !r_v_i) && !q_empty) begin
                deq        = 1'b1;
                ram_v_o    = head_v;
                ram_w_o    = head_v;
                ram_idx_o  = head_v ? head_idx  : '0;
                ram_data_o = head_v ? head_data : '0;
            end else if (r_v_i) begin
                ram_v_o    = 1'b1;
                ram_idx_o  = r_idx_i;
                r_yumi_o   = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        starve_next = '0;
        case (state_reg)
            e_normal: begin
                if (q_full && !deq) begin
                    if (starve_reg == starve_width_lp'(starve_limit_p - 1)) begin
                        state_next = e_force;
                    end else begin
                        starve_next = starve_reg + starve_width_lp'(1);
                    end
                end
            end
            e_force: begin
                if (q_empty) state_next = e_normal;
            end
            default: state_next = e_normal;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= e_normal;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

`ifdef BP_FE_PRED_ARB_PERF_EN
    logic [31:0] perf_stall_reg, perf_drop_reg, perf_force_reg;
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, perf_drop_reg} + 33'(inv_hits);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_stall_reg <= '0;
            perf_drop_reg  <= '0;
            perf_force_reg <= '0;
        end else begin
            if (r_v_i && !r_yumi_o && !(&perf_stall_reg)) perf_stall_reg <= perf_stall_reg + 32'd1;
            perf_drop_reg <= drop_sum[32] ? '1 : drop_sum[31:0];
            if (state_reg == e_normal && state_next == e_force && !(&perf_force_reg))
                perf_force_reg <= perf_force_reg + 32'd1;
        end
    end

    assign perf_read_stall_o   = perf_stall_reg;
    assign perf_attaboy_drop_o = perf_drop_reg;
    assign perf_force_o        = perf_force_reg;
`else
    logic unused_inv_hits;
    assign unused_inv_hits = ^inv_hits;
`endif

endmodule

// File: tb/tb_bp_fe_pred_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the arbiter.
module tb_bp_fe_pred_port_arbiter;

    localparam int IW = 9;
    localparam int DW = 2;
    localparam int FE = 4;
    localparam int SL = 8;

    logic          clk_i;
    logic          reset_i;
    logic          redirect_v_i;
    logic [IW-1:0] redirect_idx_i;
    logic [DW-1:0] redirect_data_i;
    logic          r_v_i;
    logic [IW-1:0] r_idx_i;
    logic          r_yumi_o;
    logic          attaboy_v_i;
    logic [IW-1:0] attaboy_idx_i;
    logic [DW-1:0] attaboy_data_i;
    logic          attaboy_yumi_o;
    logic          ram_v_o;
    logic          ram_w_o;
    logic [IW-1:0] ram_idx_o;
    logic [DW-1:0] ram_data_o;
    logic          forced_drain_o;
`ifdef BP_FE_PRED_ARB_PERF_EN
    logic [31:0]   perf_read_stall_o, perf_attaboy_drop_o, perf_force_o;
`endif

    bp_fe_pred_port_arbiter #(
        .idx_width_p(IW), .data_width_p(DW), .fifo_els_p(FE), .starve_limit_p(SL)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .redirect_v_i   (redirect_v_i),
        .redirect_idx_i (redirect_idx_i),
        .redirect_data_i(redirect_data_i),
        .r_v_i          (r_v_i),
        .r_idx_i        (r_idx_i),
        .r_yumi_o       (r_yumi_o),
        .attaboy_v_i    (attaboy_v_i),
        .attaboy_idx_i  (attaboy_idx_i),
        .attaboy_data_i (attaboy_data_i),
        .attaboy_yumi_o (attaboy_yumi_o),
        .ram_v_o        (ram_v_o),
        .ram_w_o        (ram_w_o),
        .ram_idx_o      (ram_idx_o),
        .ram_data_o     (ram_data_o),
        .forced_drain_o (forced_drain_o)
`ifdef BP_FE_PRED_ARB_PERF_EN
        ,
        .perf_read_stall_o  (perf_read_stall_o),
        .perf_attaboy_drop_o(perf_attaboy_drop_o),
        .perf_force_o       (perf_force_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } ent_t;

    // Behavioural model: pending attaboys in arrival order, starvation run length, force flag.
    ent_t mq[$];
    int   m_starve;
    bit   m_force;

    int   checks;
    int   failures;

    logic          last_ram_v, last_ram_w, last_ryumi, last_aby, last_forced;
    logic [IW-1:0] last_ram_idx;
    logic [DW-1:0] last_ram_data;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model, clock.
    task automatic step(input bit rst, input bit rdv, input int rdi, input int rdd,
                        input bit rv, input int ri, input bit av, input int ai, input int ad);
        bit e_rv, e_rw, e_ry, e_ay, e_fd, pop, full;
        int e_ri, e_rd;
        reset_i         = rst;
        redirect_v_i    = rdv;
        redirect_idx_i  = IW'(rdi);
        redirect_data_i = DW'(rdd);
        r_v_i           = rv;
        r_idx_i         = IW'(ri);
        attaboy_v_i     = av;
        attaboy_idx_i   = IW'(ai);
        attaboy_data_i  = DW'(ad);
        #1;
        e_rv = 0; e_rw = 0; e_ry = 0; e_ay = 0; e_fd = 0; pop = 0;
        e_ri = 0; e_rd = 0;
        full = (mq.size() == FE);
        if (!rst) begin
            e_fd = m_force;
            e_ay = av && !full;
            if (rdv) begin
                e_rv = 1; e_rw = 1; e_ri = rdi; e_rd = rdd;
            end else if (mq.size() > 0 && (m_force || !rv)) begin
                pop = 1;
                e_rv = mq[0].v; e_rw = mq[0].v; e_ri = int'(mq[0].idx); e_rd = int'(mq[0].data);
            end else if (rv) begin
                e_rv = 1; e_ri = ri; e_ry = 1;
            end
        end
        chk("ram_v", int'(ram_v_o), int'(e_rv));
        if (e_rv) begin
            chk("ram_w", int'(ram_w_o), int'(e_rw));
            chk("ram_idx", int'(ram_idx_o), e_ri);
            if (e_rw) chk("ram_data", int'(ram_data_o), e_rd);
        end
        chk("r_yumi", int'(r_yumi_o), int'(e_ry));
        chk("attaboy_yumi", int'(attaboy_yumi_o), int'(e_ay));
        chk("forced_drain", int'(forced_drain_o), int'(e_fd));
        last_ram_v = ram_v_o; last_ram_w = ram_w_o; last_ram_idx = ram_idx_o;
        last_ram_data = ram_data_o; last_ryumi = r_yumi_o; last_aby = attaboy_yumi_o;
        last_forced = forced_drain_o;
        if (rst) begin
            mq.delete(); m_starve = 0; m_force = 0;
        end else begin
            if (!m_force) begin
                if (full && !pop) begin
                    if (m_starve + 1 == SL) begin m_force = 1; m_starve = 0; end
                    else m_starve++;
                end else m_starve = 0;
            end else if (mq.size() == 0) m_force = 0;
            if (pop) void'(mq.pop_front());
            if (rdv) foreach (mq[k]) if (mq[k].idx == IW'(rdi)) mq[k].v = 1'b0;
            if (e_ay) mq.push_back('{1'b1, IW'(ai), DW'(ad)});
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Fill the queue under continuous lookups, then starve it into forced drain.
    task automatic fill_force(input int base);
        for (int k = 0; k < FE; k++) begin
            step(0, 0, 0, 0, 1, 9'h1AA, 1, base + k, k);
            chk("fill_aby", int'(last_aby), 1);
        end
        for (int k = 0; k < SL; k++) begin
            step(0, 0, 0, 0, 1, 9'h1AA, 1, 200, 0);
            chk("full_aby", int'(last_aby), 0);
            chk("full_not_forced", int'(last_forced), 0);
        end
    endtask

    initial begin
        bit pend;
        int pidx;
        bit rst_r;
        checks = 0; failures = 0; m_starve = 0; m_force = 0;
        reset_i = 1; redirect_v_i = 0; redirect_idx_i = '0; redirect_data_i = '0;
        r_v_i = 0; r_idx_i = '0; attaboy_v_i = 0; attaboy_idx_i = '0; attaboy_data_i = '0;
        @(posedge clk_i); #1;

        // Reset: all outputs low even with every request asserted.
        step(1, 1, 1, 1, 1, 2, 1, 3, 1);
        step(1, 1, 1, 1, 1, 2, 1, 3, 1);
        chk("rst_ram_v", int'(last_ram_v), 0);
        chk("rst_r_yumi", int'(last_ryumi), 0);
        chk("rst_aby", int'(last_aby), 0);

        // Redirect + read + attaboy together on an empty queue.
        step(0, 1, 10, 1, 1, 20, 1, 30, 2);
        chk("t1_ram_w", int'(last_ram_w), 1);
        chk("t1_ram_idx", int'(last_ram_idx), 10);
        chk("t1_r_yumi", int'(last_ryumi), 0);
        chk("t1_aby", int'(last_aby), 1);
        step(0, 0, 0, 0, 1, 20, 0, 0, 0);
        chk("t1_read_w", int'(last_ram_w), 0);
        chk("t1_read_idx", int'(last_ram_idx), 20);
        chk("t1_read_yumi", int'(last_ryumi), 1);
        idle();
        chk("t1_drain_idx", int'(last_ram_idx), 30);
        chk("t1_drain_data", int'(last_ram_data), 2);

        // Starvation forces four back-to-back drains ahead of held lookups.
        fill_force(40);
        for (int k = 0; k < FE; k++) begin
            step(0, 0, 0, 0, 1, 9'h1AA, 0, 0, 0);
            chk("t2_forced", int'(last_forced), 1);
            chk("t2_drain_w", int'(last_ram_w), 1);
            chk("t2_drain_idx", int'(last_ram_idx), 40 + k);
            chk("t2_r_yumi", int'(last_ryumi), 0);
        end
        step(0, 0, 0, 0, 1, 9'h1AA, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9'h1AA, 0, 0, 0);
        chk("t2_back_normal", int'(last_forced), 0);

        // Redirect to idx 5 invalidates both queued idx-5 entries.
        step(0, 0, 0, 0, 1, 21, 1, 5, 1);
        step(0, 0, 0, 0, 1, 21, 1, 7, 2);
        step(0, 0, 0, 0, 1, 21, 1, 5, 3);
        step(0, 1, 5, 0, 1, 21, 0, 0, 0);
        chk("t3_redirect_idx", int'(last_ram_idx), 5);
        idle();
        chk("t3_pop0_ram_v", int'(last_ram_v), 0);
        idle();
        chk("t3_pop1_ram_v", int'(last_ram_v), 1);
        chk("t3_pop1_idx", int'(last_ram_idx), 7);
        idle();
        chk("t3_pop2_ram_v", int'(last_ram_v), 0);

        // Attaboy arriving with a same-idx redirect is younger and survives.
        step(0, 1, 3, 2, 1, 22, 1, 3, 1);
        chk("t4_aby", int'(last_aby), 1);
        idle();
        chk("t4_drain_v", int'(last_ram_v), 1);
        chk("t4_drain_idx", int'(last_ram_idx), 3);
        chk("t4_drain_data", int'(last_ram_data), 1);

        // Reset while forced with three entries queued discards them.
        fill_force(50);
        step(0, 0, 0, 0, 1, 9'h1AA, 0, 0, 0);
        chk("t5_forced", int'(last_forced), 1);
        chk("t5_drain_idx", int'(last_ram_idx), 50);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t5_no_drain", int'(last_ram_v), 0);
            chk("t5_normal", int'(last_forced), 0);
        end

        // Enqueue + dequeue at count 2 across pointer wrap.
        step(0, 0, 0, 0, 1, 23, 1, 100, 0);
        step(0, 0, 0, 0, 1, 23, 1, 101, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 102 + i, (2 + i) % 4);
            chk("t6_drain_idx", int'(last_ram_idx), 100 + i);
            chk("t6_drain_data", int'(last_ram_data), i % 4);
            chk("t6_aby", int'(last_aby), 1);
        end
        idle();
        idle();
        idle();
        chk("t6_empty", int'(last_ram_v), 0);

        // Random traffic against the model; lookups held until granted.
        pend = 0; pidx = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1;
                pidx = int'($urandom_range(0, 7));
            end
            step(rst_r, $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 pend, pidx, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            if (last_ryumi) pend = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
